banked_command_queue: RTL and testbench

- Next-generation per-bank command queue array with a single shared enqueue port and a single shared issue port.
- Each bank holds a FIFO of parametrised depth.
- A round-robin arbiter picks one non-empty bank head per cycle and issues it to the DRAM command bus under a valid/ready handshake.
- Sits between the per-bank request schedulers (PRE/ACT/CAS generation) and the command bus timing checker. Adds configurable depth, per-bank flush, occupancy reporting and a slot-reservation admission rule.

---
 rtl/banked_command_queue.sv | 155 +++++++++++++++
 tb/tb_banked_command_queue.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_command_queue.sv
// Per-bank command FIFOs behind one shared enqueue port and one
// round-robin issue port, with flush, occupancy and admission flags.
module banked_command_queue #(
  parameter int NUM_BNK_TOT    = 16,
  parameter int DEPTH          = 4,
  parameter int CMD_TYPE_WIDTH = 3,
  parameter int ADDR_WIDTH     = 18,
  parameter int DATA_PTR_WIDTH = 4,
  parameter int OPEN_SLOTS     = 3
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_enq_valid,
  input  logic [$clog2(NUM_BNK_TOT)-1:0]               i_enq_bank,
  input  logic [CMD_TYPE_WIDTH-1:0]                    i_enq_cmd,
  input  logic [ADDR_WIDTH-1:0]                        i_enq_addr,
  input  logic [DATA_PTR_WIDTH-1:0]                    i_enq_data_ptr,
  output logic                                         o_enq_ready,
  input  logic [NUM_BNK_TOT-1:0]                       i_flush,
  output logic                                         o_issue_valid,
  output logic [$clog2(NUM_BNK_TOT)-1:0]               o_issue_bank,
  output logic [CMD_TYPE_WIDTH-1:0]                    o_issue_cmd,
  output logic [ADDR_WIDTH-1:0]                        o_issue_addr,
  output logic [DATA_PTR_WIDTH-1:0]                    o_issue_data_ptr,
  input  logic                                         i_issue_ready,
  output logic [NUM_BNK_TOT*($clog2(DEPTH)+1)-1:0]     o_count,
  output logic [NUM_BNK_TOT-1:0]                       o_empty,
  output logic [NUM_BNK_TOT-1:0]                       o_full,
  output logic [NUM_BNK_TOT-1:0]                       o_open_request_allowed,
  output logic [NUM_BNK_TOT-1:0]                       o_close_request_allowed
);

  localparam int BW = $clog2(NUM_BNK_TOT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [CMD_TYPE_WIDTH-1:0] cmd;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_PTR_WIDTH-1:0] ptr;
  } entry_t;

  entry_t        mem    [NUM_BNK_TOT][DEPTH];
  logic [PW-1:0] rd_ptr [NUM_BNK_TOT];
  logic [PW-1:0] wr_ptr [NUM_BNK_TOT];
  logic [CW-1:0] cnt    [NUM_BNK_TOT];
  logic [BW-1:0] rr_ptr;

  logic [NUM_BNK_TOT-1:0] empty;
  logic [NUM_BNK_TOT-1:0] full;
  logic [NUM_BNK_TOT-1:0] elig;
  logic [NUM_BNK_TOT-1:0] push;
  logic [NUM_BNK_TOT-1:0] pop;
  logic                   enq_fire;
  logic                   issue_fire;
  logic                   any_elig;
  logic [BW-1:0]          grant;
  logic [BW-1:0]          rr_next;
  entry_t                 enq_entry;
  entry_t                 head;
  int                     k;

  for (genvar b = 0; b < NUM_BNK_TOT; b++) begin : g_stat
    assign empty[b] = (cnt[b] == '0);
    assign full[b]  = (cnt[b] == CW'(DEPTH));
    assign o_count[b*CW +: CW] = cnt[b];
    assign o_open_request_allowed[b] =
      (DEPTH - int'(cnt[b])) >= OPEN_SLOTS;
    assign o_close_request_allowed[b] = !full[b];
  end

  assign o_empty = empty;
  assign o_full  = full;
  assign elig    = ~empty & ~i_flush;

  assign o_enq_ready = !full[i_enq_bank] && !i_flush[i_enq_bank];
  assign enq_fire    = i_enq_valid && o_enq_ready;

  assign enq_entry.cmd  = i_enq_cmd;
  assign enq_entry.addr = i_enq_addr;
  assign enq_entry.ptr  = i_enq_data_ptr;

  // First eligible bank at or after the RR pointer, wrapping around
  always_comb begin
    grant    = '0;
    any_elig = 1'b0;
    k        = 0;
    for (int i = 0; i < NUM_BNK_TOT; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_BNK_TOT) k = k - NUM_BNK_TOT;
      if (!any_elig && elig[k]) begin
        any_elig = 1'b1;
        grant    = BW'(k);
      end
    end
  end

  assign head       = mem[grant][rd_ptr[grant]];
  assign issue_fire = any_elig && i_issue_ready;
  assign rr_next    = (grant == BW'(NUM_BNK_TOT - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    o_issue_valid    = any_elig;
    o_issue_bank     = '0;
    o_issue_cmd      = '0;
    o_issue_addr     = '0;
    o_issue_data_ptr = '0;
    if (any_elig) begin
      o_issue_bank     = grant;
      o_issue_cmd      = head.cmd;
      o_issue_addr     = head.addr;
      o_issue_data_ptr = head.ptr;
    end
  end

  always_comb begin
    push = '0;
    pop  = '0;
    if (enq_fire)   push[i_enq_bank] = 1'b1;
    if (issue_fire) pop[grant]       = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (enq_fire)
      mem[i_enq_bank][wr_ptr[i_enq_bank]] <= enq_entry;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr <= '0;
      for (int b = 0; b < NUM_BNK_TOT; b++) begin
        cnt[b]    <= '0;
        rd_ptr[b] <= '0;
        wr_ptr[b] <= '0;
      end
    end else begin
      if (issue_fire) rr_ptr <= rr_next;
      for (int b = 0; b < NUM_BNK_TOT; b++) begin
        if (i_flush[b]) begin
          cnt[b]    <= '0;
          rd_ptr[b] <= '0;
          wr_ptr[b] <= '0;
        end else begin
          if (push[b]) wr_ptr[b] <= wr_ptr[b] + 1'b1;
          if (pop[b])  rd_ptr[b] <= rd_ptr[b] + 1'b1;
          if (push[b] && !pop[b])
            cnt[b] <= cnt[b] + 1'b1;
          else if (pop[b] && !push[b])
            cnt[b] <= cnt[b] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_banked_command_queue.sv
// Directed bench for banked_command_queue: fill/drain, RR order,
// full-bank refusal, flush regrant, back-to-back, async reset.
module tb_banked_command_queue;

  localparam int N  = 16;
  localparam int BW = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          enq_valid;
  logic [BW-1:0] enq_bank;
  logic [2:0]    enq_cmd;
  logic [17:0]   enq_addr;
  logic [3:0]    enq_ptr;
  logic          enq_ready;
  logic [N-1:0]  flush;
  logic          issue_valid;
  logic [BW-1:0] issue_bank;
  logic [2:0]    issue_cmd;
  logic [17:0]   issue_addr;
  logic [3:0]    issue_ptr;
  logic          issue_ready;
  logic [N*CW-1:0] count;
  logic [N-1:0]  empty;
  logic [N-1:0]  full;
  logic [N-1:0]  open_ok;
  logic [N-1:0]  close_ok;

  int total;
  int passed;

  banked_command_queue dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_enq_valid             (enq_valid),
    .i_enq_bank              (enq_bank),
    .i_enq_cmd               (enq_cmd),
    .i_enq_addr              (enq_addr),
    .i_enq_data_ptr          (enq_ptr),
    .o_enq_ready             (enq_ready),
    .i_flush                 (flush),
    .o_issue_valid           (issue_valid),
    .o_issue_bank            (issue_bank),
    .o_issue_cmd             (issue_cmd),
    .o_issue_addr            (issue_addr),
    .o_issue_data_ptr        (issue_ptr),
    .i_issue_ready           (issue_ready),
    .o_count                 (count),
    .o_empty                 (empty),
    .o_full                  (full),
    .o_open_request_allowed  (open_ok),
    .o_close_request_allowed (close_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int b);
    return count[b*CW +: CW];
  endfunction

  task automatic set_enq(input logic v, input logic [BW-1:0] b,
                         input logic [2:0] c, input logic [17:0] a,
                         input logic [3:0] p);
    enq_valid = v;
    enq_bank  = b;
    enq_cmd   = c;
    enq_addr  = a;
    enq_ptr   = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    settle();
    total++;
    if (empty !== 16'hFFFF)
      $display("FAIL rst_empty got %h want ffff", empty);
    else passed++;
    total++;
    if (full !== 16'h0000)
      $display("FAIL rst_full got %h want 0000", full);
    else passed++;
    total++;
    if ({issue_valid, issue_bank, issue_cmd, issue_addr, issue_ptr} !== 30'd0)
      $display("FAIL rst_issue got v=%b b=%0d c=%0d a=%h p=%0d want all 0",
               issue_valid, issue_bank, issue_cmd, issue_addr, issue_ptr);
    else passed++;
    total++;
    if (enq_ready !== 1'b1)
      $display("FAIL rst_enq_ready got %b want 1", enq_ready);
    else passed++;
    total++;
    if ({open_ok, close_ok} !== 32'hFFFF_FFFF)
      $display("FAIL rst_admit got %h/%h want ffff/ffff", open_ok, close_ok);
    else passed++;
  endtask

  task automatic test_fill_drain();
    logic exp_open;
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 4'd5, 3'(i), 18'(256 + i), 4'(i));
      settle();
      total++;
      if (enq_ready !== 1'b1)
        $display("FAIL fill_ready%0d got %b want 1", i, enq_ready);
      else passed++;
      if (i == 0) begin
        total++;
        if (issue_valid !== 1'b0)
          $display("FAIL fill_no_bypass got %b want 0", issue_valid);
        else passed++;
      end
      cyc();
      exp_open = (i == 0);
      total++;
      if (cnt_of(5) !== 3'(i + 1) || open_ok[5] !== exp_open)
        $display("FAIL fill_cnt%0d got cnt=%0d open=%b want cnt=%0d open=%b",
                 i, cnt_of(5), open_ok[5], i + 1, exp_open);
      else passed++;
    end
    total++;
    if (full[5] !== 1'b1 || close_ok[5] !== 1'b0)
      $display("FAIL fill_full got full=%b close=%b want 1/0",
               full[5], close_ok[5]);
    else passed++;
    set_enq(1'b1, 4'd5, 3'd7, 18'h3ffff, 4'hf);
    settle();
    total++;
    if (enq_ready !== 1'b0)
      $display("FAIL fill_5th_ready got %b want 0", enq_ready);
    else passed++;
    cyc();
    set_enq(1'b0, 4'd0, 3'd0, 18'd0, 4'd0);
    total++;
    if (cnt_of(5) !== 3'd4)
      $display("FAIL fill_5th_cnt got %0d want 4", cnt_of(5));
    else passed++;
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      total++;
      if ({issue_valid, issue_bank, issue_cmd, issue_addr, issue_ptr} !==
          {1'b1, 4'd5, 3'(i), 18'(256 + i), 4'(i)})
        $display("FAIL drain%0d got v=%b b=%0d c=%0d a=%h p=%0d want 1/5/%0d/%h/%0d",
                 i, issue_valid, issue_bank, issue_cmd, issue_addr, issue_ptr,
                 i, 256 + i, i);
      else passed++;
      cyc();
    end
    total++;
    if (issue_valid !== 1'b0 || empty[5] !== 1'b1)
      $display("FAIL drain_end got v=%b empty=%b want 0/1",
               issue_valid, empty[5]);
    else passed++;
    issue_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [BW-1:0] exp_bank [5];
    exp_bank[0] = 4'd0;
    exp_bank[1] = 4'd3;
    exp_bank[2] = 4'd15;
    exp_bank[3] = 4'd0;
    exp_bank[4] = 4'd1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    issue_ready = 1'b0;
    set_enq(1'b1, 4'd0, 3'd1, 18'd0, 4'd0);
    cyc();
    set_enq(1'b1, 4'd3, 3'd2, 18'd0, 4'd0);
    cyc();
    set_enq(1'b1, 4'd15, 3'd3, 18'd0, 4'd0);
    cyc();
    issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1)
        set_enq(1'b1, 4'd1, 3'd4, 18'd0, 4'd0);
      else if (i == 2)
        set_enq(1'b1, 4'd0, 3'd5, 18'd0, 4'd0);
      else
        set_enq(1'b0, 4'd0, 3'd0, 18'd0, 4'd0);
      settle();
      total++;
      if (issue_valid !== 1'b1 || issue_bank !== exp_bank[i])
        $display("FAIL rr_order%0d got v=%b b=%0d want 1/%0d",
                 i, issue_valid, issue_bank, exp_bank[i]);
      else passed++;
      cyc();
    end
    total++;
    if (issue_valid !== 1'b0)
      $display("FAIL rr_end got %b want 0", issue_valid);
    else passed++;
    issue_ready = 1'b0;
  endtask

  task automatic test_full_same_cycle();
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 4'd2, 3'(i + 1), 18'd0, 4'd0);
      cyc();
    end
    set_enq(1'b1, 4'd2, 3'd7, 18'd0, 4'd0);
    issue_ready = 1'b1;
    settle();
    total++;
    if (enq_ready !== 1'b0 || issue_bank !== 4'd2 || issue_cmd !== 3'd1)
      $display("FAIL full_same got rdy=%b b=%0d c=%0d want 0/2/1",
               enq_ready, issue_bank, issue_cmd);
    else passed++;
    cyc();
    set_enq(1'b0, 4'd0, 3'd0, 18'd0, 4'd0);
    total++;
    if (cnt_of(2) !== 3'd3)
      $display("FAIL full_cnt got %0d want 3", cnt_of(2));
    else passed++;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++;
      if (issue_cmd !== 3'(i + 2))
        $display("FAIL full_drain%0d got c=%0d want %0d",
                 i, issue_cmd, i + 2);
      else passed++;
      cyc();
    end
    total++;
    if (empty[2] !== 1'b1 || issue_valid !== 1'b0)
      $display("FAIL full_end got empty=%b v=%b want 1/0",
               empty[2], issue_valid);
    else passed++;
    issue_ready = 1'b0;
  endtask

  task automatic test_flush();
    issue_ready = 1'b0;
    set_enq(1'b1, 4'd7, 3'd5, 18'd0, 4'd0);
    cyc();
    set_enq(1'b1, 4'd9, 3'd6, 18'd0, 4'd0);
    cyc();
    set_enq(1'b0, 4'd7, 3'd0, 18'd0, 4'd0);
    settle();
    total++;
    if (issue_bank !== 4'd7)
      $display("FAIL flush_pre got b=%0d want 7", issue_bank);
    else passed++;
    flush = 16'h0080;
    settle();
    total++;
    if (issue_valid !== 1'b1 || issue_bank !== 4'd9 || issue_cmd !== 3'd6)
      $display("FAIL flush_regrant got v=%b b=%0d c=%0d want 1/9/6",
               issue_valid, issue_bank, issue_cmd);
    else passed++;
    total++;
    if (enq_ready !== 1'b0)
      $display("FAIL flush_enq_ready got %b want 0", enq_ready);
    else passed++;
    cyc();
    flush = '0;
    settle();
    total++;
    if (cnt_of(7) !== 3'd0 || empty[7] !== 1'b1 || cnt_of(9) !== 3'd1)
      $display("FAIL flush_post got c7=%0d e7=%b c9=%0d want 0/1/1",
               cnt_of(7), empty[7], cnt_of(9));
    else passed++;
    issue_ready = 1'b1;
    cyc();
    issue_ready = 1'b0;
    total++;
    if (issue_valid !== 1'b0)
      $display("FAIL flush_end got %b want 0", issue_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    issue_ready = 1'b0;
    set_enq(1'b1, 4'd6, 3'd1, 18'd0, 4'd0);
    cyc();
    set_enq(1'b1, 4'd6, 3'd2, 18'd0, 4'd0);
    issue_ready = 1'b1;
    settle();
    total++;
    if (enq_ready !== 1'b1 || issue_bank !== 4'd6 || issue_cmd !== 3'd1)
      $display("FAIL b2b_pre got rdy=%b b=%0d c=%0d want 1/6/1",
               enq_ready, issue_bank, issue_cmd);
    else passed++;
    cyc();
    set_enq(1'b0, 4'd0, 3'd0, 18'd0, 4'd0);
    issue_ready = 1'b0;
    settle();
    total++;
    if (cnt_of(6) !== 3'd1 || issue_cmd !== 3'd2)
      $display("FAIL b2b_post got cnt=%0d c=%0d want 1/2",
               cnt_of(6), issue_cmd);
    else passed++;
    issue_ready = 1'b1;
    cyc();
    issue_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    issue_ready = 1'b0;
    set_enq(1'b1, 4'd4, 3'd3, 18'd0, 4'd0);
    cyc();
    set_enq(1'b1, 4'd10, 3'd4, 18'd0, 4'd0);
    cyc();
    set_enq(1'b1, 4'd12, 3'd5, 18'd0, 4'd0);
    cyc();
    set_enq(1'b0, 4'd0, 3'd0, 18'd0, 4'd0);
    settle();
    total++;
    if (issue_valid !== 1'b1 || issue_bank !== 4'd10)
      $display("FAIL arst_pre got v=%b b=%0d want 1/10",
               issue_valid, issue_bank);
    else passed++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (empty !== 16'hFFFF || count !== '0 || issue_valid !== 1'b0 ||
        issue_bank !== 4'd0 || open_ok !== 16'hFFFF)
      $display("FAIL arst_now got e=%h cnt=%h v=%b b=%0d open=%h want ffff/0/0/0/ffff",
               empty, count, issue_valid, issue_bank, open_ok);
    else passed++;
    #1;
    rst = 1'b0;
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (issue_valid !== 1'b0)
        $display("FAIL arst_stale%0d got v=%b b=%0d want v=0",
                 i, issue_valid, issue_bank);
      else passed++;
    end
    issue_ready = 1'b0;
    set_enq(1'b1, 4'd4, 3'd6, 18'd0, 4'd0);
    cyc();
    set_enq(1'b0, 4'd0, 3'd0, 18'd0, 4'd0);
    settle();
    total++;
    if (issue_bank !== 4'd4 || issue_cmd !== 3'd6 || cnt_of(4) !== 3'd1)
      $display("FAIL arst_new got b=%0d c=%0d cnt=%0d want 4/6/1",
               issue_bank, issue_cmd, cnt_of(4));
    else passed++;
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    rst         = 1'b1;
    flush       = '0;
    issue_ready = 1'b0;
    set_enq(1'b0, 4'd0, 3'd0, 18'd0, 4'd0);
    test_reset();
    test_fill_drain();
    test_round_robin();
    test_full_same_cycle();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
